// File: rtl/booth_seq_multiplier.sv
// -----------------------------------------------------------------------------
// booth_seq_multiplier
//
// Sequential two's-complement multiplier. The multiplicand S and multiplier B
// are combined by iterative conditional add-and-shift through a WIDTH+1-bit
// sign-extended adder. The final iteration subtracts S, which makes the result
// correct when the multiplier is negative. The product is {Aval,Bval}.
//
// Build option:
//   BOOTH_MULT_FUSED_STEP_EN  when defined, the ADD and SHIFT states merge into
//                             one STEP state (WIDTH busy cycles instead of
//                             2*WIDTH). Products are identical either way.
//
// Ports:
//   Clk      in   system clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   Load_B   in   level; B <= Din and clear A, X (IDLE only)
//   Run      in   level; start a multiply with S <= Din (IDLE only, wins
//                 over Load_B)
//   Din      in   [WIDTH] operand input
//   Aval     out  [WIDTH] upper product half / accumulator A
//   Bval     out  [WIDTH] lower product half / multiplier B
//   Xval     out  sign-extension bit X
//   Busy     out  high while the multiply is iterating
//   Done     out  high in DONE until Run is released
// -----------------------------------------------------------------------------
module booth_seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Load_B,
   input  logic             Run,
   input  logic [WIDTH-1:0] Din,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             Xval,
   output logic             Busy,
   output logic             Done
);

   // state | meaning
   // IDLE  | accept Load_B / Run
   // ADD   | conditional add (subtract on last step) of S into {X,A}
   // SHIFT | arithmetic right shift of {X,A,B}, advance step counter
   // STEP  | fused build only: add and shift in one cycle
   // DONE  | product valid, wait for Run to drop

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

`ifdef BOOTH_MULT_FUSED_STEP_EN
   typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
`endif

   state_t state_q, state_d;

   logic [WIDTH-1:0] a_q, b_q, s_q;
   logic             x_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q, done_q;

   logic             last_step;
   logic [WIDTH:0]   a_ext, s_ext, addend, sum;

   assign last_step = (cnt_q == LAST_STEP);
   assign a_ext     = {a_q[WIDTH-1], a_q};
   assign s_ext     = {s_q[WIDTH-1], s_q};
   // The multiplier's sign bit arrives in B[0] on the last step; its weight
   // is negative, so S is subtracted rather than added there.
   assign addend    = last_step ? (~s_ext + (WIDTH+1)'(1)) : s_ext;
   assign sum       = a_ext + addend;

`ifdef BOOTH_MULT_FUSED_STEP_EN
   logic [WIDTH:0] step_val;
   assign step_val = b_q[0] ? sum : {x_q, a_q};
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
`ifdef BOOTH_MULT_FUSED_STEP_EN
            if (Run) state_d = STEP;
`else
            if (Run) state_d = ADD;
`endif
         end
`ifdef BOOTH_MULT_FUSED_STEP_EN
         STEP:  if (last_step) state_d = DONE;
`else
         ADD:   state_d = SHIFT;
         SHIFT: state_d = last_step ? DONE : ADD;
`endif
         DONE:  if (!Run) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Busy/Done are registered from the next state so every output is a flop.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
`ifdef BOOTH_MULT_FUSED_STEP_EN
         busy_q  <= (state_d == STEP);
`else
         busy_q  <= (state_d == ADD) || (state_d == SHIFT);
`endif
         done_q  <= (state_d == DONE);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         a_q   <= '0;
         b_q   <= '0;
         s_q   <= '0;
         x_q   <= 1'b0;
         cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Run) begin
                  s_q   <= Din;
                  a_q   <= '0;
                  x_q   <= 1'b0;
                  cnt_q <= '0;
               end else if (Load_B) begin
                  b_q <= Din;
                  a_q <= '0;
                  x_q <= 1'b0;
               end
            end
`ifdef BOOTH_MULT_FUSED_STEP_EN
            STEP: begin
               {x_q, a_q, b_q} <= {step_val[WIDTH], step_val, b_q[WIDTH-1:1]};
               cnt_q           <= cnt_q + 1'b1;
            end
`else
            ADD: begin
               if (b_q[0]) begin
                  x_q <= sum[WIDTH];
                  a_q <= sum[WIDTH-1:0];
               end
            end
            SHIFT: begin
               {x_q, a_q, b_q} <= {x_q, x_q, a_q, b_q[WIDTH-1:1]};
               cnt_q           <= cnt_q + 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign Aval = a_q;
   assign Bval = b_q;
   assign Xval = x_q;
   assign Busy = busy_q;
   assign Done = done_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_multiplier
//
// Directed and random bench for booth_seq_multiplier (WIDTH=8). The expected
// product is plain signed multiplication of the modelled B register and the
// operand presented with Run. Works for both builds of
// BOOTH_MULT_FUSED_STEP_EN; only the expected busy length changes.
// -----------------------------------------------------------------------------
module tb_booth_seq_multiplier;

   localparam int W = 8;
`ifdef BOOTH_MULT_FUSED_STEP_EN
   localparam int BUSY_CYC = W;
`else
   localparam int BUSY_CYC = 2 * W;
`endif

   logic         Clk = 1'b0;
   logic         Reset_n = 1'b0;
   logic         Load_B = 1'b0;
   logic         Run = 1'b0;
   logic [W-1:0] Din = '0;
   logic [W-1:0] Aval, Bval;
   logic         Xval, Busy, Done;

   booth_seq_multiplier #(.WIDTH(W)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .Load_B  (Load_B),
      .Run     (Run),
      .Din     (Din),
      .Aval    (Aval),
      .Bval    (Bval),
      .Xval    (Xval),
      .Busy    (Busy),
      .Done    (Done)
   );

   always #5 Clk = ~Clk;

   int vectors = 0;
   int miscompares = 0;
   logic [W-1:0] m_b = '0;   // model of the B register

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [W-1:0] d);
      @(negedge Clk);
      Load_B = 1'b1;
      Din    = d;
      @(negedge Clk);
      Load_B = 1'b0;
      m_b    = d;
      check("load_b", 32'(Bval), 32'(d));
      check("load_ax", 32'({Aval, Xval}), 32'(0));
   endtask

   task automatic do_run(input logic [W-1:0] d, input bit with_load, input int hold);
      logic signed [W-1:0]   bs, ss;
      logic signed [2*W-1:0] p;
      logic [2*W-1:0]        pu;
      int busy_n;
      bit seen;
      @(negedge Clk);
      Run    = 1'b1;
      Load_B = with_load;
      Din    = d;
      bs = m_b;
      ss = d;
      p  = bs * ss;
      pu = p;
      busy_n = 0;
      seen   = 1'b0;
      for (int i = 0; i < 4 * W + 8; i++) begin
         @(negedge Clk);
         if (Done) begin
            seen = 1'b1;
            break;
         end
         if (Busy) busy_n++;
         Load_B = 1'($urandom_range(0, 1));
         Din    = W'($urandom);
      end
      Load_B = 1'b0;
      check("done_seen", 32'(seen), 32'(1));
      check("busy_cycles", 32'(busy_n), 32'(BUSY_CYC));
      check("product", 32'({Aval, Bval}), 32'(pu));
      check("xval", 32'(Xval), 32'(pu[2*W-1]));
      check("busy_at_done", 32'(Busy), 32'(0));
      for (int i = 0; i < hold; i++) begin
         @(negedge Clk);
         check("done_held", 32'({Done, Busy}), 32'(2'b10));
         check("hold_product", 32'({Aval, Bval}), 32'(pu));
      end
      Run = 1'b0;
      @(negedge Clk);
      check("idle_flags", 32'({Done, Busy}), 32'(0));
      check("idle_product", 32'({Aval, Bval}), 32'(pu));
      m_b = pu[W-1:0];
   endtask

   initial begin
      int n;

      // Reset state, with a clock edge while reset is held
      #12;
      check("reset_out", 32'({Aval, Bval, Xval, Busy, Done}), 32'(0));
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      check("post_reset", 32'({Aval, Bval, Xval, Busy, Done}), 32'(0));

      // -59 * 7 = -413
      do_load(8'hC5);
      do_run(8'h07, 1'b0, 0);
      check("tc1_const", 32'({Xval, Aval, Bval}), 32'({1'b1, 16'hFE63}));

      // -128 * -128 = 16384
      do_load(8'h80);
      do_run(8'h80, 1'b0, 0);
      check("tc2_const", 32'({Xval, Aval, Bval}), 32'({1'b0, 16'h4000}));

      // -1 * -1, Run held after Done, then rerun with B = 0x01
      do_load(8'hFF);
      do_run(8'hFF, 1'b0, 10);
      check("tc3_const", 32'({Xval, Aval, Bval}), 32'({1'b0, 16'h0001}));
      do_run(8'h9D, 1'b0, 0);

      // Asynchronous reset in the middle of a run
      do_load(8'h5A);
      @(negedge Clk);
      Run = 1'b1;
      Din = 8'h33;
      n = 0;
      for (int i = 0; i < 4 * W; i++) begin
         @(negedge Clk);
         if (Busy) n++;
         if (n == 5) break;
      end
      check("mid_reset_reached", 32'(n), 32'(5));
      #2 Reset_n = 1'b0;
      #1;
      check("mid_reset_out", 32'({Aval, Bval, Xval, Busy, Done}), 32'(0));
      Run = 1'b0;
      m_b = '0;
      @(negedge Clk);
      Reset_n = 1'b1;
      do_load(8'h21);
      do_run(8'hE7, 1'b0, 0);

      // Load_B and Run together: Run wins, B keeps 0x05
      do_load(8'h05);
      do_run(8'h03, 1'b1, 0);
      check("tc5_const", 32'({Xval, Aval, Bval}), 32'({1'b0, 16'h000F}));

      // Random operands, sometimes reusing the previous low half as B
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 2) != 0) do_load(W'($urandom));
         do_run(W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
